// File: rtl/spi_adc_reader.sv
// SPI mode-0 master that reads 16-bit frames from a PMOD ADC.
// Completed frames go to a valid/ready holding register that detects overruns.
module spi_adc_reader #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic        start,
  input  logic        clear_overrun,
  output logic        spi_csb,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic        sample_ready,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [15:0] raw_frame,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned BIT_W      = 5;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    sample_c;
  logic                    capture_c;
  logic                    overrun_evt_c;

  assign spi_mosi = 1'b0;

  // State and counter registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // Next-state logic; every state's dwell time is counted down from a reload value
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sample_c  = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable || start) begin
          state_d = SETUP;
          cnt_d   = HALF_LOAD;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d  = SHIFT_HI;
          cnt_d    = HALF_LOAD;
          bit_d    = bit_q + BIT_W'(1);
          sample_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_q == '0) begin
          state_d = SHIFT_LO;
          cnt_d   = HALF_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT_LO: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bit_q == LAST_BIT) begin
          capture_c = 1'b1;
          if (enable) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          state_d  = SHIFT_HI;
          cnt_d    = HALF_LOAD;
          bit_d    = bit_q + BIT_W'(1);
          sample_c = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (enable) begin
          state_d = SETUP;
          cnt_d   = HALF_LOAD;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign overrun_evt_c = capture_c && sample_valid && !sample_ready;

  // SPI pins, shift register and the sample holding register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      spi_csb      <= 1'b1;
      spi_sck      <= 1'b0;
      busy         <= 1'b0;
      shift_q      <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      raw_frame    <= '0;
      overrun      <= 1'b0;
    end else begin
      spi_csb <= (state_d == IDLE) || (state_d == GAP);
      spi_sck <= (state_d == SHIFT_HI);
      busy    <= (state_d != IDLE);
      if (sample_c) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], spi_miso};
      end
      // A capture on the same edge as a consume keeps the new frame valid
      if (capture_c) begin
        sample_valid <= 1'b1;
        raw_frame    <= shift_q;
        sample_data  <= shift_q[15:4];
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (overrun_evt_c) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
